// File: rtl/aes_enc_stream_core_pkg.sv
// aes_enc_stream_core_pkg: AES byte-level helpers, S-box table and FSM state codes.
package aes_enc_stream_core_pkg;

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_ROUND = 2'd1;
   localparam logic [1:0] S_DONE  = 2'd2;

   localparam logic [2047:0] SBOX_TBL = {
      128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};

   function automatic int nr_of(input int key_bits);
      return (key_bits == 256) ? 14 : 10;
   endfunction

   function automatic logic [7:0] sbox(input logic [7:0] b);
      return SBOX_TBL[11'd2047 - {b, 3'b000} -: 8];
   endfunction

   function automatic logic [31:0] sub_word(input logic [31:0] w);
      logic [31:0] r;
      for (int i = 0; i < 4; i++) r[8*i +: 8] = sbox(w[8*i +: 8]);
      return r;
   endfunction

   function automatic logic [127:0] sub_bytes(input logic [127:0] s);
      logic [127:0] r;
      for (int i = 0; i < 16; i++) r[8*i +: 8] = sbox(s[8*i +: 8]);
      return r;
   endfunction

   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   // byte k of the block sits at [127-8k]; column c, row w is byte 4c+w
   function automatic logic [127:0] shift_rows(input logic [127:0] s);
      logic [127:0] r;
      for (int c = 0; c < 4; c++)
         for (int w = 0; w < 4; w++)
            r[127-8*(4*c+w) -: 8] = s[127-8*(4*((c+w)%4)+w) -: 8];
      return r;
   endfunction

   function automatic logic [127:0] mix_columns(input logic [127:0] s);
      logic [127:0] r;
      logic [7:0] a0, a1, a2, a3;
      for (int c = 0; c < 4; c++) begin
         {a0, a1, a2, a3} = s[127-32*c -: 32];
         r[127-32*c -: 32] = {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                              a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                              a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                              xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
      end
      return r;
   endfunction

endpackage

// File: rtl/aes_enc_stream_core_key_step.sv
// aes_enc_stream_core_key_step: derives the next 128-bit key half from the previous half
// and the last word of the most recent half (rot=1 adds RotWord and Rcon).
module aes_enc_stream_core_key_step
   import aes_enc_stream_core_pkg::*;
(
   input  logic [127:0] k_i,
   input  logic [31:0]  prev_w_i,
   input  logic [7:0]   rcon_i,
   input  logic         rot_i,
   output logic [127:0] k_o
);
   logic [31:0] t, w0, w1, w2, w3;
   always_comb begin
      t  = rot_i ? (sub_word({prev_w_i[23:0], prev_w_i[31:24]}) ^ {rcon_i, 24'h0}) : sub_word(prev_w_i);
      w0 = k_i[127:96] ^ t;
      w1 = k_i[95:64] ^ w0;
      w2 = k_i[63:32] ^ w1;
      w3 = k_i[31:0] ^ w2;
      k_o = {w0, w1, w2, w3};
   end
endmodule

// File: rtl/aes_enc_stream_core.sv
// aes_enc_stream_core: iterative one-round-per-cycle AES-128/256 encryptor with valid/ready streaming.
// Define AES_KEY_HOLD_EN to add key_load_i and encrypt with a held key register.
module aes_enc_stream_core
   import aes_enc_stream_core_pkg::*;
#(
   parameter int KEY_BITS = 128
) (
   input  logic                clk_i,
   input  logic                rst_ni,
`ifdef AES_KEY_HOLD_EN
   input  logic                key_load_i,
`endif
   input  logic                in_valid_i,
   output logic                in_ready_o,
   input  logic [127:0]        plain_text_i,
   input  logic [KEY_BITS-1:0] key_i,
   output logic                out_valid_o,
   input  logic                out_ready_i,
   output logic [127:0]        dout_o,
   output logic                busy_o
);
   localparam int NR = nr_of(KEY_BITS);
   localparam logic [3:0] LAST = 4'(NR);

   logic [1:0]          state_q, state_d;
   logic [3:0]          cnt_q, cnt_d;
   logic [7:0]          rcon_q, rcon_d;
   logic [127:0]        st_q, st_d, dout_q, dout_d;
   logic [127:0]        rk_cur, sr, rnd;
   logic [KEY_BITS-1:0] k_sel;
   logic                accept, in_round, rcon_adv;

`ifdef AES_KEY_HOLD_EN
   logic [KEY_BITS-1:0] hold_q;
   always_ff @(posedge clk_i or negedge rst_ni)
      if (!rst_ni) hold_q <= '0;
      else if (key_load_i) hold_q <= key_i;
   assign k_sel = hold_q;
`else
   assign k_sel = key_i;
`endif

   assign in_ready_o  = (state_q == S_IDLE) | ((state_q == S_DONE) & out_ready_i);
   assign accept      = in_valid_i & in_ready_o;
   assign in_round    = state_q == S_ROUND;
   assign busy_o      = in_round;
   assign out_valid_o = state_q == S_DONE;
   assign dout_o      = dout_q;
   assign sr          = shift_rows(sub_bytes(st_q));
   assign rnd         = ((cnt_q == LAST) ? sr : mix_columns(sr)) ^ rk_cur;

   generate
      if (KEY_BITS == 128) begin : g_k128
         logic [127:0] rk_q, rk_d;
         aes_enc_stream_core_key_step u_step (
            .k_i(rk_q), .prev_w_i(rk_q[31:0]), .rcon_i(rcon_q), .rot_i(1'b1), .k_o(rk_d));
         assign rk_cur   = rk_d;
         assign rcon_adv = 1'b1;
         always_ff @(posedge clk_i or negedge rst_ni)
            if (!rst_ni) rk_q <= '0;
            else if (accept) rk_q <= k_sel;
            else if (in_round) rk_q <= rk_d;
      end else if (KEY_BITS == 256) begin : g_k256
         // kb holds the current round key; ka/kb slide forward one half per round
         logic [127:0] ka_q, kb_q, kn;
         aes_enc_stream_core_key_step u_step (
            .k_i(ka_q), .prev_w_i(kb_q[31:0]), .rcon_i(rcon_q), .rot_i(cnt_q[0]), .k_o(kn));
         assign rk_cur   = kb_q;
         assign rcon_adv = cnt_q[0];
         always_ff @(posedge clk_i or negedge rst_ni)
            if (!rst_ni) begin
               ka_q <= '0;
               kb_q <= '0;
            end else if (accept) begin
               ka_q <= k_sel[255:128];
               kb_q <= k_sel[127:0];
            end else if (in_round) begin
               ka_q <= kb_q;
               kb_q <= kn;
            end
      end else begin : g_bad_key_bits
         $error("aes_enc_stream_core: KEY_BITS must be 128 or 256");
      end
   endgenerate

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      rcon_d  = rcon_q;
      st_d    = st_q;
      dout_d  = dout_q;
      if (accept) begin
         state_d = S_ROUND;
         cnt_d   = 4'd1;
         rcon_d  = 8'h01;
         st_d    = plain_text_i ^ k_sel[KEY_BITS-1 -: 128];
      end else if (in_round) begin
         cnt_d   = cnt_q + 4'd1;
         rcon_d  = rcon_adv ? xtime(rcon_q) : rcon_q;
         st_d    = rnd;
         state_d = (cnt_q == LAST) ? S_DONE : S_ROUND;
         dout_d  = (cnt_q == LAST) ? rnd : dout_q;
      end else if (state_q == S_DONE && out_ready_i) begin
         state_d = S_IDLE;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni)
      if (!rst_ni) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         rcon_q  <= 8'h01;
         st_q    <= '0;
         dout_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rcon_q  <= rcon_d;
         st_q    <= st_d;
         dout_q  <= dout_d;
      end
endmodule

// File: tb/tb_aes_enc_stream_core.sv
// tb_aes_enc_stream_core: drives an AES-128 and an AES-256 instance with known-answer and random
// blocks, comparing against a word-oriented FIPS-197 model with a computed S-box.
module tb_aes_enc_stream_core;
   localparam logic [255:0] K1 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
   localparam logic [127:0] P1 = 128'h3243f6a8885a308d313198a2e0370734;
   localparam logic [127:0] V1 = 128'h3925841d02dc09fbdc118597196a0b32;
   localparam logic [255:0] K2 = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
   localparam logic [127:0] P2 = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] V2 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [255:0] K3 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
   localparam logic [127:0] V3 = 128'h8ea2b7ca516745bfeafc49904b496089;

   logic clk = 1'b0, rst_n = 1'b0;
   logic in_valid [2], in_ready [2], out_valid [2], out_ready [2], busy [2];
   logic [127:0] pt [2], dout [2];
   logic [255:0] key [2];
   logic [7:0] sb [256];
   int n_tests = 0, n_fail = 0, cyc = 0;
`ifdef AES_KEY_HOLD_EN
   logic key_load [2];
`endif

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   aes_enc_stream_core #(.KEY_BITS(128)) u_dut128 (
      .clk_i(clk), .rst_ni(rst_n),
`ifdef AES_KEY_HOLD_EN
      .key_load_i(key_load[0]),
`endif
      .in_valid_i(in_valid[0]), .in_ready_o(in_ready[0]), .plain_text_i(pt[0]), .key_i(key[0][255:128]),
      .out_valid_o(out_valid[0]), .out_ready_i(out_ready[0]), .dout_o(dout[0]), .busy_o(busy[0]));

   aes_enc_stream_core #(.KEY_BITS(256)) u_dut256 (
      .clk_i(clk), .rst_ni(rst_n),
`ifdef AES_KEY_HOLD_EN
      .key_load_i(key_load[1]),
`endif
      .in_valid_i(in_valid[1]), .in_ready_o(in_ready[1]), .plain_text_i(pt[1]), .key_i(key[1]),
      .out_valid_o(out_valid[1]), .out_ready_i(out_ready[1]), .dout_o(dout[1]), .busy_o(busy[1]));

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p = 8'h00;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p ^= a;
         a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
      end
      return p;
   endfunction

   // S-box from the GF(2^8) inverse (x^254) followed by the affine transform
   task automatic build_sbox;
      logic [7:0] inv;
      for (int x = 0; x < 256; x++) begin
         inv = 8'h01;
         for (int i = 0; i < 254; i++) inv = gmul(inv, 8'(x));
         sb[x] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
      end
   endtask

   function automatic logic [31:0] subw(input logic [31:0] w);
      return {sb[w[31:24]], sb[w[23:16]], sb[w[15:8]], sb[w[7:0]]};
   endfunction

   // key is left-aligned: AES-128 uses key[255:128]
   function automatic logic [127:0] aes_ref(input logic [127:0] p, input logic [255:0] k, input int nk);
      logic [31:0] w [60];
      logic [31:0] tmp;
      logic [7:0] s [16], t [16], a0, a1, a2, a3, rc;
      logic [127:0] r;
      int nr;
      nr = nk + 6;
      rc = 8'h01;
      for (int i = 0; i < nk; i++) w[i] = k[255-32*i -: 32];
      for (int i = nk; i < 4*(nr+1); i++) begin
         tmp = w[i-1];
         if (i % nk == 0) begin
            tmp = subw({tmp[23:0], tmp[31:24]}) ^ {rc, 24'h0};
            rc = gmul(rc, 8'h02);
         end else if (nk > 6 && i % nk == 4) tmp = subw(tmp);
         w[i] = w[i-nk] ^ tmp;
      end
      for (int i = 0; i < 16; i++) s[i] = p[127-8*i -: 8] ^ w[i/4][31-8*(i%4) -: 8];
      for (int rd = 1; rd <= nr; rd++) begin
         for (int i = 0; i < 16; i++) s[i] = sb[s[i]];
         for (int c = 0; c < 4; c++)
            for (int rw = 0; rw < 4; rw++) t[rw+4*c] = s[rw+4*((c+rw)%4)];
         for (int c = 0; c < 4; c++) begin
            {a0, a1, a2, a3} = {t[4*c], t[4*c+1], t[4*c+2], t[4*c+3]};
            if (rd < nr) begin
               s[4*c]   = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
               s[4*c+1] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
               s[4*c+2] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
               s[4*c+3] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
            end else {s[4*c], s[4*c+1], s[4*c+2], s[4*c+3]} = {a0, a1, a2, a3};
         end
         for (int i = 0; i < 16; i++) s[i] ^= w[4*rd + i/4][31-8*(i%4) -: 8];
      end
      for (int i = 0; i < 16; i++) r[127-8*i -: 8] = s[i];
      return r;
   endfunction

   function automatic logic [127:0] rnd128();
      return {$urandom(), $urandom(), $urandom(), $urandom()};
   endfunction

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic load_key(input int d, input logic [255:0] k);
`ifdef AES_KEY_HOLD_EN
      key[d] = k;
      key_load[d] = 1'b1;
      step;
      key_load[d] = 1'b0;
      key[d] = '0;
`else
      key[d] = k;
`endif
   endtask

   // offer one block, wait for the result, stall the sink for `hold` cycles, then consume
   task automatic push(input int d, input logic [127:0] p, input logic [127:0] exp, input int hold);
      int lat, nr;
      nr = (d == 0) ? 10 : 14;
      pt[d] = p;
      in_valid[d] = 1'b1;
      check("in_ready_idle", in_ready[d], 1);
      step;
      in_valid[d] = 1'b0;
      pt[d] = rnd128();
      key[d] = {rnd128(), rnd128()};
      check("busy_after_accept", busy[d], 1);
      lat = 0;
      while (!out_valid[d] && lat < 40) begin
         step;
         lat++;
      end
      check("latency", lat, nr);
      check("dout", dout[d], exp);
      for (int i = 0; i < hold; i++) begin
         step;
         check("dout_hold", dout[d], exp);
         check("in_ready_stall", {in_ready[d], out_valid[d]}, 2'b01);
      end
      out_ready[d] = 1'b1;
      step;
      out_ready[d] = 1'b0;
      check("consumed", {out_valid[d], in_ready[d], busy[d]}, 3'b010);
   endtask

   initial begin
      int c1, c2, n;
      logic [255:0] k;
      logic [127:0] p;
      for (int d = 0; d < 2; d++) begin
         in_valid[d] = 1'b0;
         out_ready[d] = 1'b0;
         pt[d] = '0;
         key[d] = '0;
`ifdef AES_KEY_HOLD_EN
         key_load[d] = 1'b0;
`endif
      end
      build_sbox();
      #12;
      for (int d = 0; d < 2; d++) check("reset_outputs", {dout[d], out_valid[d], busy[d]}, '0);
      @(negedge clk) rst_n = 1'b1;
      step;
      check("reset_in_ready", {in_ready[0], in_ready[1]}, 2'b11);

      load_key(0, K1);
      push(0, P1, V1, 0);
      load_key(0, K2);
      push(0, P2, V2, 5);
      load_key(1, K3);
      push(1, P2, V3, 2);

      for (int i = 0; i < 6; i++)
         for (int d = 0; d < 2; d++) begin
            k = {rnd128(), rnd128()};
            p = rnd128();
            load_key(d, k);
            push(d, p, aes_ref(p, k, (d == 0) ? 4 : 8), $urandom_range(0, 3));
         end

      // back-to-back: second accept lands on the cycle the first result is consumed
      load_key(0, K1);
      pt[0] = P1;
      key[0] = K1;
      in_valid[0] = 1'b1;
      out_ready[0] = 1'b1;
      step;
      pt[0] = P2;
      key[0] = K2;
`ifdef AES_KEY_HOLD_EN
      key_load[0] = 1'b1;
      step;
      key_load[0] = 1'b0;
`endif
      n = 0;
      while (!out_valid[0] && n < 40) begin
         step;
         n++;
      end
      c1 = cyc;
      check("b2b_first", dout[0], V1);
      step;
      in_valid[0] = 1'b0;
      check("b2b_reaccept", {busy[0], out_valid[0]}, 2'b10);
      n = 0;
      while (!out_valid[0] && n < 40) begin
         step;
         n++;
      end
      c2 = cyc;
      check("b2b_spacing", c2 - c1, 11);
      check("b2b_second", dout[0], V2);
      step;
      out_ready[0] = 1'b0;
      check("b2b_idle", {out_valid[0], in_ready[0]}, 2'b01);

      // asynchronous reset in the middle of a block
      load_key(0, K1);
      pt[0] = P1;
      in_valid[0] = 1'b1;
      step;
      in_valid[0] = 1'b0;
      repeat (4) step;
      check("midop_busy", {busy[0], dout[0]}, {1'b1, V2});
      rst_n = 1'b0;
      #1;
      check("midop_reset", {out_valid[0], busy[0], dout[0]}, '0);
      @(negedge clk) rst_n = 1'b1;
      step;
      check("midop_no_valid", {out_valid[0], in_ready[0]}, 2'b01);
      load_key(0, K1);
      push(0, P1, V1, 1);

`ifdef AES_KEY_HOLD_EN
      load_key(0, K1);
      for (int i = 0; i < 2; i++) begin
         key[0] = '0;
         push(0, P1, V1, 0);
      end
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
